// File: rtl/binary_bbox_detector.sv
// Per-frame bounding box and foreground count over a binary edge stream.
// Results are published with a one-cycle frame_done strobe at each vsync rise.
//
//   state | meaning
//   IDLE  | no frame boundary seen since reset; the next vsync rise only re-arms
//   ACCUM | accumulating a frame; each vsync rise publishes and re-arms
module binary_bbox_detector #(
  parameter int   IMG_WIDTH   = 640,
  parameter int   IMG_HEIGHT  = 480,
  parameter int   EDGE_MARGIN = 2,
  parameter logic FG_LEVEL    = 1'b0,
  parameter int   MIN_PIXELS  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        per_frame_vsync,
  input  logic        per_frame_href,
  input  logic        per_frame_clken,
  input  logic        per_img_Bit,
  output logic [10:0] box_x_min,
  output logic [10:0] box_x_max,
  output logic [10:0] box_y_min,
  output logic [10:0] box_y_max,
  output logic [20:0] box_pixel_cnt,
  output logic        box_found,
  output logic        frame_done
);

  typedef enum logic {IDLE, ACCUM} state_t;

  localparam logic [10:0] X_LO      = 11'(EDGE_MARGIN);
  localparam logic [10:0] X_HI      = 11'(IMG_WIDTH - EDGE_MARGIN);
  localparam logic [10:0] Y_LO      = 11'(EDGE_MARGIN);
  localparam logic [10:0] Y_HI      = 11'(IMG_HEIGHT - EDGE_MARGIN);
  localparam logic [10:0] COORD_MAX = '1;
  localparam logic [20:0] CNT_MAX   = '1;
  localparam logic [20:0] MIN_CNT   = 21'(MIN_PIXELS);

  state_t      state;
  logic        vsync_s, vsync_d, href_d;
  logic [10:0] x, y;
  logic [10:0] acc_x_min, acc_x_max, acc_y_min, acc_y_max;
  logic [20:0] acc_cnt;

  logic pix_acc, href_fall, frame_rise, in_win, fg_hit, acc_found;

  assign pix_acc    = per_frame_href & per_frame_clken & ~per_frame_vsync;
  assign href_fall  = href_d & ~per_frame_href;
  assign frame_rise = vsync_s & ~vsync_d;
  assign in_win     = (x >= X_LO) && (x < X_HI) && (y >= Y_LO) && (y < Y_HI);
  assign fg_hit     = pix_acc & in_win & (per_img_Bit == FG_LEVEL);
  assign acc_found  = (acc_cnt >= MIN_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      vsync_s       <= 1'b0;
      vsync_d       <= 1'b0;
      href_d        <= 1'b0;
      x             <= '0;
      y             <= '0;
      acc_x_min     <= COORD_MAX;
      acc_x_max     <= '0;
      acc_y_min     <= COORD_MAX;
      acc_y_max     <= '0;
      acc_cnt       <= '0;
      box_x_min     <= '0;
      box_x_max     <= '0;
      box_y_min     <= '0;
      box_y_max     <= '0;
      box_pixel_cnt <= '0;
      box_found     <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      vsync_s    <= per_frame_vsync;
      vsync_d    <= vsync_s;
      href_d     <= per_frame_href;
      frame_done <= 1'b0;

      if (href_fall)
        x <= '0;
      else if (pix_acc && x != COORD_MAX)
        x <= x + 11'd1;

      // href activity during blanking must not push the next frame's first row
      if (frame_rise)
        y <= '0;
      else if (href_fall && !per_frame_vsync && y != COORD_MAX)
        y <= y + 11'd1;

      if (frame_rise) begin
        if (state == IDLE) begin
          state <= ACCUM;
        end else begin
          box_pixel_cnt <= acc_cnt;
          box_found     <= acc_found;
          box_x_min     <= acc_found ? acc_x_min : '0;
          box_x_max     <= acc_found ? acc_x_max : '0;
          box_y_min     <= acc_found ? acc_y_min : '0;
          box_y_max     <= acc_found ? acc_y_max : '0;
          frame_done    <= 1'b1;
        end
        acc_x_min <= COORD_MAX;
        acc_x_max <= '0;
        acc_y_min <= COORD_MAX;
        acc_y_max <= '0;
        acc_cnt   <= '0;
      end else if (fg_hit) begin
        if (x < acc_x_min) acc_x_min <= x;
        if (x > acc_x_max) acc_x_max <= x;
        if (y < acc_y_min) acc_y_min <= y;
        if (y > acc_y_max) acc_y_max <= y;
        if (acc_cnt != CNT_MAX) acc_cnt <= acc_cnt + 21'd1;
      end
    end
  end

endmodule

// File: tb/tb_binary_bbox_detector.sv
// Randomized and directed bench for binary_bbox_detector; two instances differ only in MIN_PIXELS.
`timescale 1ns/1ps
module tb_binary_bbox_detector;

  localparam int W = 16;
  localparam int H = 12;
  localparam int M = 1;
  localparam int MIN_A = 1;
  localparam int MIN_B = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vsync = 1'b0, href = 1'b0, clken = 1'b0, bitv = 1'b1;

  logic [10:0] xmn [2];
  logic [10:0] xmx [2];
  logic [10:0] ymn [2];
  logic [10:0] ymx [2];
  logic [20:0] cnt [2];
  logic        fnd [2];
  logic        done [2];

  binary_bbox_detector #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .EDGE_MARGIN(M),
                         .FG_LEVEL(1'b0), .MIN_PIXELS(MIN_A)) u_a (
    .clk(clk), .rst(rst), .per_frame_vsync(vsync), .per_frame_href(href),
    .per_frame_clken(clken), .per_img_Bit(bitv),
    .box_x_min(xmn[0]), .box_x_max(xmx[0]), .box_y_min(ymn[0]), .box_y_max(ymx[0]),
    .box_pixel_cnt(cnt[0]), .box_found(fnd[0]), .frame_done(done[0]));

  binary_bbox_detector #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .EDGE_MARGIN(M),
                         .FG_LEVEL(1'b0), .MIN_PIXELS(MIN_B)) u_b (
    .clk(clk), .rst(rst), .per_frame_vsync(vsync), .per_frame_href(href),
    .per_frame_clken(clken), .per_img_Bit(bitv),
    .box_x_min(xmn[1]), .box_x_max(xmx[1]), .box_y_min(ymn[1]), .box_y_max(ymx[1]),
    .box_pixel_cnt(cnt[1]), .box_found(fnd[1]), .frame_done(done[1]));

  always #5 clk = ~clk;

  // Reference state: foreground pixels of the current frame, and the expected outputs.
  int          qx[$];
  int          qy[$];
  logic [65:0] exp_v [2];
  logic [65:0] res_v [2];
  logic [65:0] snap  [2];
  bit          exp_done, pend, seen, vs_prev;
  int          n_cmp = 0, n_err = 0, nstb = 0;
  bit          img [0:15][0:19];

  function automatic logic [65:0] pk(input int a, input int b, input int c, input int e,
                                     input int n, input int f);
    return {11'(a), 11'(b), 11'(c), 11'(e), 21'(n), 1'(f)};
  endfunction

  function automatic logic [65:0] dut_pk(input int d);
    return {xmn[d], xmx[d], ymn[d], ymx[d], cnt[d], fnd[d]};
  endfunction

  function automatic logic [65:0] frame_result(input int minp);
    int n, xl, xh, yl, yh;
    n = 0; xl = 2047; xh = 0; yl = 2047; yh = 0;
    foreach (qx[i]) begin
      if (qx[i] >= M && qx[i] < W - M && qy[i] >= M && qy[i] < H - M) begin
        n++;
        if (qx[i] < xl) xl = qx[i];
        if (qx[i] > xh) xh = qx[i];
        if (qy[i] < yl) yl = qy[i];
        if (qy[i] > yh) yh = qy[i];
      end
    end
    if (n > 2097151) n = 2097151;
    if (n >= minp) return pk(xl, xh, yl, yh, n, 1);
    return pk(0, 0, 0, 0, n, 0);
  endfunction

  task automatic model_reset();
    exp_v[0] = '0; exp_v[1] = '0;
    exp_done = 0; pend = 0; seen = 0; vs_prev = 0;
    qx.delete(); qy.delete();
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else begin
      exp_done = 0;
      if (pend) begin
        exp_v[0] = res_v[0]; exp_v[1] = res_v[1];
        exp_done = 1; pend = 0;
      end
      if (vsync && !vs_prev) begin
        res_v[0] = frame_result(MIN_A);
        res_v[1] = frame_result(MIN_B);
        if (seen) pend = 1;
        seen = 1;
        qx.delete(); qy.delete();
      end
      vs_prev = vsync;
    end
  endtask

  task automatic compare_outputs();
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if ({dut_pk(d), done[d]} !== {exp_v[d], exp_done}) begin
        n_err++;
        $display("FAIL cycle_check dut%0d @%0t: got box/cnt/found=%h done=%b, want %h done=%b",
                 d, $time, dut_pk(d), done[d], exp_v[d], exp_done);
      end
    end
    if (done[0]) begin
      nstb++;
      snap[0] = dut_pk(0);
      snap[1] = dut_pk(1);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk(input string name, input logic [66:0] act, input logic [66:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic clear_img();
    foreach (img[r, c]) img[r][c] = 1'b0;
  endtask

  // gap_mode: 0 none, 1 clken low every other cycle, 2 random gaps.
  // short_last > 0: last row has that many columns and href is left high.
  task automatic drive_frame(input int cols, input int rows, input int gap_mode, input int short_last);
    int ncol, c;
    bit ph, en, last_short;
    for (int r = 0; r < rows; r++) begin
      last_short = (short_last > 0) && (r == rows - 1);
      ncol = last_short ? short_last : cols;
      c = 0; ph = 0;
      href = 1'b1;
      while (c < ncol) begin
        if (gap_mode == 1) begin en = ph; ph = ~ph; end
        else if (gap_mode == 2) en = ($urandom_range(0, 3) != 0);
        else en = 1;
        clken = en;
        bitv = en ? ~img[r][c] : 1'($urandom_range(0, 1));
        if (en) begin
          if (img[r][c]) begin qx.push_back(c); qy.push_back(r); end
          c++;
        end
        tick();
      end
      if (!last_short) begin
        href = 1'b0; clken = 1'b0; bitv = 1'b1;
        repeat ($urandom_range(1, 3)) tick();
      end
    end
  endtask

  // rogue: a foreground pixel presented in the same cycle vsync rises.
  task automatic vsync_pulse(input int len, input bit rogue);
    vsync = 1'b1;
    if (rogue) begin href = 1'b1; clken = 1'b1; bitv = 1'b0; end
    tick();
    href = 1'b0; clken = 1'b0; bitv = 1'b1;
    repeat (len - 1) tick();
    vsync = 1'b0;
    tick();
  endtask

  int s0;

  initial begin
    model_reset();
    clear_img();
    repeat (3) tick();
    chk("reset_a", {dut_pk(0), done[0]}, '0);
    chk("reset_b", {dut_pk(1), done[1]}, '0);
    rst = 1'b0;
    repeat (2) tick();

    s0 = nstb; vsync_pulse(4, 0);
    chk("first_vsync_no_strobe", 67'(nstb - s0), 67'(0));

    clear_img(); img[3][5] = 1;
    drive_frame(W, H, 0, 0);
    s0 = nstb; vsync_pulse(3, 0);
    chk("dot_strobes", 67'(nstb - s0), 67'(1));
    chk("dot_a", 67'(snap[0]), 67'(pk(5, 5, 3, 3, 1, 1)));
    chk("dot_b", 67'(snap[1]), 67'(pk(0, 0, 0, 0, 1, 0)));

    clear_img();
    for (int r = 2; r <= 7; r++) for (int c = 4; c <= 9; c++) img[r][c] = 1;
    drive_frame(W, H, 1, 0);
    s0 = nstb; vsync_pulse(3, 0);
    chk("rect_strobes", 67'(nstb - s0), 67'(1));
    chk("rect_a", 67'(snap[0]), 67'(pk(4, 9, 2, 7, 36, 1)));
    chk("rect_b", 67'(snap[1]), 67'(pk(4, 9, 2, 7, 36, 1)));

    clear_img();
    for (int c = 0; c < W; c++) begin img[0][c] = 1; img[H-1][c] = 1; end
    for (int r = 0; r < H; r++) begin img[r][0] = 1; img[r][W-1] = 1; end
    drive_frame(W, H, 2, 0);
    s0 = nstb; vsync_pulse(3, 0);
    chk("margin_strobes", 67'(nstb - s0), 67'(1));
    chk("margin_a", 67'(snap[0]), '0);
    chk("margin_b", 67'(snap[1]), '0);

    clear_img(); img[3][3] = 1; img[4][6] = 1; img[8][8] = 1;
    drive_frame(W, H, 0, 0);
    s0 = nstb; vsync_pulse(3, 0);
    chk("thr3_strobes", 67'(nstb - s0), 67'(1));
    chk("thr3_a", 67'(snap[0]), 67'(pk(3, 8, 3, 8, 3, 1)));
    chk("thr3_b", 67'(snap[1]), 67'(pk(0, 0, 0, 0, 3, 0)));

    // Short last row leaves x=6, y=9 (in window) for the pixel sent with the vsync rise.
    img[2][10] = 1;
    drive_frame(W, 10, 0, 6);
    s0 = nstb; vsync_pulse(50, 1);
    chk("long_vsync_strobes", 67'(nstb - s0), 67'(1));
    chk("thr4_a", 67'(snap[0]), 67'(pk(3, 10, 2, 8, 4, 1)));
    chk("thr4_b", 67'(snap[1]), 67'(pk(3, 10, 2, 8, 4, 1)));

    clear_img();
    for (int c = 2; c <= 6; c++) begin img[2][c] = 1; img[3][c] = 1; end
    drive_frame(W, 5, 0, 0);
    rst = 1'b1;
    #1;
    chk("midreset_a", {dut_pk(0), done[0]}, '0);
    chk("midreset_b", {dut_pk(1), done[1]}, '0);
    model_reset();
    repeat (2) tick();
    rst = 1'b0;
    tick();
    s0 = nstb; vsync_pulse(3, 0);
    chk("post_reset_no_strobe", 67'(nstb - s0), 67'(0));
    clear_img();
    for (int r = 5; r <= 6; r++) for (int c = 7; c <= 8; c++) img[r][c] = 1;
    drive_frame(W, H, 2, 0);
    s0 = nstb; vsync_pulse(3, 0);
    chk("post_reset_strobes", 67'(nstb - s0), 67'(1));
    chk("post_reset_a", 67'(snap[0]), 67'(pk(7, 8, 5, 6, 4, 1)));
    chk("post_reset_b", 67'(snap[1]), 67'(pk(7, 8, 5, 6, 4, 1)));

    clear_img();
    drive_frame(W, H, 2, 0);
    s0 = nstb; vsync_pulse(3, 0);
    chk("empty_strobes", 67'(nstb - s0), 67'(1));
    chk("empty_a", 67'(snap[0]), '0);

    for (int f = 0; f < 25; f++) begin
      int dens;
      dens = $urandom_range(3, 30);
      foreach (img[r, c]) img[r][c] = ($urandom_range(0, dens) == 0);
      drive_frame($urandom_range(14, 18), $urandom_range(10, 14), 2, 0);
      vsync_pulse($urandom_range(2, 6), 0);
    end

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/binary_bbox_detector.md
# binary_bbox_detector

Consumes the binary edge stream produced by the Sobel stage and measures, per frame, the bounding box and count of foreground pixels. It is the downstream reader of the post_frame_vsync / post_frame_href / post_frame_clken / post_img_Bit interface. At each frame boundary it publishes the digit region to the recognition logic as a one-cycle result strobe.

## Interface
- IMG_WIDTH, 640: active pixels per line.
- IMG_HEIGHT, 480: active lines per frame.
- EDGE_MARGIN, 2: border pixels ignored on every side, to suppress Sobel border artefacts.
- FG_LEVEL, 1'b0: per_img_Bit value treated as foreground. The upstream stage drives 0 for an edge.
- MIN_PIXELS, 16: minimum foreground count for a box to be reported as found.

Ports:
- clk  in  1  pixel clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- per_frame_vsync  in  1  high during vertical blanking; a rising edge marks a frame boundary.
- per_frame_href  in  1  high during active line.
- per_frame_clken  in  1  pixel-valid qualifier.
- per_img_Bit  in  1  binary pixel.
- box_x_min, box_x_max  out  11  column bounds, inclusive.
- box_y_min, box_y_max  out  11  row bounds, inclusive.
- box_pixel_cnt  out  21  foreground pixels counted in the previous frame.
- box_found  out  1  box_pixel_cnt >= MIN_PIXELS for the previous frame.
- frame_done  out  1  one-cycle strobe; all box_* outputs are updated in that same cycle.

## Operation
- **Pixel acceptance:** a pixel is accepted when per_frame_href & per_frame_clken & !per_frame_vsync.
- **Column counter x:**
  - Increments on each accepted pixel and saturates at 2047.
  - Clears to 0 in the cycle after href falls.
- **Row counter y:**
  - Increments on each href falling edge and saturates at 2047.
  - Clears to 0 on a vsync rising edge.
- **In-window test:** a pixel is in window when EDGE_MARGIN <= x < IMG_WIDTH-EDGE_MARGIN and EDGE_MARGIN <= y < IMG_HEIGHT-EDGE_MARGIN. Extra pixels or lines beyond the nominal size are ignored, with no error.
- **Foreground update:** an accepted, in-window pixel with per_img_Bit == FG_LEVEL updates the accumulators:
  - acc_x_min = min(acc_x_min, x), acc_x_max = max(acc_x_max, x); same for y.
  - acc_cnt += 1, saturating at 2^21-1.
- **Accumulator initial values:** min = 2047, max = 0, cnt = 0.
- **Frame boundary:** vsync rising edge, detected against a 1-cycle registered copy.
  - If a frame has been seen since reset (frame_seen = 1), latch the results:
    - box_pixel_cnt <= acc_cnt, box_found <= (acc_cnt >= MIN_PIXELS).
    - If box_found, the box outputs take the accumulator values; otherwise all four box coordinates are 0.
    - frame_done is pulsed.
  - Always re-initialise the accumulators and set frame_seen.
- **First boundary after reset:** re-initialises state only. frame_done is not pulsed and the outputs are unchanged.
- **Result states:** IDLE (frame_seen = 0) -> ACCUM on the first vsync rise. ACCUM -> ACCUM on each vsync rise, publishing results. rst returns the block to IDLE from any state.
- **Output persistence:** between strobes, the outputs hold their last published values.

## Timing
- **Reset values:** all outputs 0 and frame_seen = 0. Accumulators and counters take their initial values. Reset applied mid-frame discards that frame.
- **Accumulator latency:** an accepted pixel at edge N is reflected in the accumulators after edge N.
- **Result latency:** vsync is first sampled high at edge N. Then frame_done = 1 and the box outputs are valid from edge N+1 until edge N+2. frame_done returns to 0 at edge N+2.
- **vsync back-to-back:** vsync held high for many cycles gives exactly one strobe. Any pixel qualifiers during vsync high are ignored.
- **Pixel in the same cycle as the vsync rise:** ignored, because vsync is high.
- **Empty frame (no foreground):** box_found = 0, box coordinates = 0, box_pixel_cnt = 0, and frame_done still pulses.
- **Throughput:** one pixel per clock is sustained. clken gaps within a line must not advance x.

## Test plan
- **Single dot:** IMG_WIDTH=16, IMG_HEIGHT=12, EDGE_MARGIN=1, MIN_PIXELS=1. A single foreground pixel at (x=5, y=3), followed by a vsync rise.
  - Expected: one cycle after vsync is sampled high, frame_done=1, box = (5,5,3,3), cnt=1, found=1.
- **Rectangle with clken gaps:** a foreground rectangle at x 4..9, y 2..7, with clken low every other cycle.
  - Expected: box (4,9,2,7), cnt=36.
- **Margin rejection:** foreground pixels only at x=0, x=15, y=0 and y=11, with EDGE_MARGIN=1.
  - Expected: cnt=0, found=0, all box coordinates 0, frame_done pulses.
- **MIN_PIXELS threshold:** MIN_PIXELS=4 with 3 foreground pixels gives found=0 and box 0s. The next frame with 4 pixels gives found=1 with the correct box. frame_done is exactly one cycle wide each time.
- **First-boundary and long-vsync behaviour:** the first vsync after reset produces no frame_done. A vsync held high for 50 cycles produces exactly one strobe. A foreground pixel presented while vsync is high is not counted.
- **Reset mid-frame:** assert rst mid-frame after 10 foreground pixels.
  - Expected: outputs 0 immediately. The next vsync rise gives no strobe, and the following frame reports only its own pixels.
